// File: rtl/int_sop_chain_acc.sv
// int_sop_chain_acc
//   Cascade of STAGES integer sum-of-products slices (LANES multiplies each). Per-stage lane
//   sums ripple down a registered chain seeded from chain_in; the chain total feeds an
//   accumulator with sticky overflow detection.
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   in_valid     beat qualifier for all inputs
//   signed_mode  1: two's-complement operands/products, 0: unsigned
//   acc_en       1: accumulate beat total into result
//   acc_clear    1: beat starts a new accumulation (load, clear overflow)
//   x_flat       operand x, lane l of stage s at [(s*LANES+l)*DATA_W +: DATA_W]
//   y_flat       operand y, same packing
//   chain_in     external chain seed added at stage 0
//   result       accumulator / chain total
//   out_valid    result updated this cycle
//   overflow     sticky accumulator overflow flag
// Latency: beat sampled at edge T appears at edge T+STAGES+3
//   (input reg, product reg, lane-sum reg, STAGES chain regs, accumulator reg).
module int_sop_chain_acc #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned LANES  = 4,
  parameter int unsigned STAGES = 2,
  parameter int unsigned ACC_W  = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic                             signed_mode,
  input  logic                             acc_en,
  input  logic                             acc_clear,
  input  logic [STAGES*LANES*DATA_W-1:0]   x_flat,
  input  logic [STAGES*LANES*DATA_W-1:0]   y_flat,
  input  logic [ACC_W-1:0]                 chain_in,
  output logic [ACC_W-1:0]                 result,
  output logic                             out_valid,
  output logic                             overflow
);

  localparam int unsigned NP = STAGES * LANES;
  localparam int unsigned PW = 2 * DATA_W;
  // Control travels alongside data: input, product, lane-sum, then one slot per chain stage.
  localparam int unsigned NC = STAGES + 3;

  // Full-width product, sign- or zero-extended to the chain width.
  function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic              sm);
    logic signed [PW-1:0] ps;
    logic        [PW-1:0] pu;
    ps = $signed(a) * $signed(b);
    pu = a * b;
    if (sm) mul_ext = {{(ACC_W - PW){ps[PW-1]}}, ps};
    else    mul_ext = {{(ACC_W - PW){1'b0}}, pu};
  endfunction

  logic [NC-1:0]             v_q, sm_q, ae_q, ac_q;
  logic [NP*DATA_W-1:0]      x_q, y_q;
  logic [ACC_W-1:0]          cin_q [3];
  logic [ACC_W-1:0]          prod_q [NP];
  logic [ACC_W-1:0]          lsum_d [STAGES];
  logic [ACC_W-1:0]          stage_add [STAGES];
  logic [ACC_W-1:0]          chain_q [STAGES];

  // Input register, control pipeline, product register, chain seed delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      sm_q  <= '0;
      ae_q  <= '0;
      ac_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
      for (int i = 0; i < 3; i++) cin_q[i] <= '0;
      for (int i = 0; i < int'(NP); i++) prod_q[i] <= '0;
    end else begin
      v_q   <= {v_q[NC-2:0], in_valid};
      sm_q  <= {sm_q[NC-2:0], signed_mode};
      ae_q  <= {ae_q[NC-2:0], acc_en};
      ac_q  <= {ac_q[NC-2:0], acc_clear};
      x_q   <= x_flat;
      y_q   <= y_flat;
      cin_q[0] <= chain_in;
      cin_q[1] <= cin_q[0];
      cin_q[2] <= cin_q[1];
      for (int i = 0; i < int'(NP); i++) begin
        prod_q[i] <= mul_ext(x_q[i*DATA_W +: DATA_W], y_q[i*DATA_W +: DATA_W], sm_q[0]);
      end
    end
  end

  always_comb begin
    for (int s = 0; s < int'(STAGES); s++) begin
      lsum_d[s] = '0;
      for (int l = 0; l < int'(LANES); l++) begin
        lsum_d[s] = lsum_d[s] + prod_q[s*LANES + l];
      end
    end
  end

  // Stage s lane sum is delayed s extra cycles so it meets the chain carrying the same beat.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [ACC_W-1:0] dly_q [s+1];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= s; k++) dly_q[k] <= '0;
      end else begin
        dly_q[0] <= lsum_d[s];
        for (int k = 1; k <= s; k++) dly_q[k] <= dly_q[k-1];
      end
    end

    assign stage_add[s] = dly_q[s];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < int'(STAGES); s++) chain_q[s] <= '0;
    end else begin
      chain_q[0] <= cin_q[2] + stage_add[0];
      for (int s = 1; s < int'(STAGES); s++) chain_q[s] <= chain_q[s-1] + stage_add[s];
    end
  end

  // Accumulator with overflow on accumulate beats only.
  logic [ACC_W-1:0] total;
  logic [ACC_W:0]   sum_ext;
  logic             ovf_now;

  always_comb begin
    total   = chain_q[STAGES-1];
    sum_ext = {1'b0, result} + {1'b0, total};
    if (sm_q[NC-1]) begin
      ovf_now = (result[ACC_W-1] == total[ACC_W-1]) &&
                (sum_ext[ACC_W-1] != result[ACC_W-1]);
    end else begin
      ovf_now = sum_ext[ACC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= v_q[NC-1];
      if (v_q[NC-1]) begin
        if (!ae_q[NC-1]) begin
          result <= total;
          if (ac_q[NC-1]) overflow <= 1'b0;
        end else if (ac_q[NC-1]) begin
          result   <= total;
          overflow <= 1'b0;
        end else begin
          result   <= sum_ext[ACC_W-1:0];
          overflow <= overflow | ovf_now;
        end
      end
    end
  end

endmodule

// File: tb/tb_int_sop_chain_acc.sv
module tb_int_sop_chain_acc;

  localparam int DW  = 9;
  localparam int NP  = 8;
  localparam int FW  = NP * DW;
  localparam int LAT = 5;

  typedef struct {
    int          due;
    logic [63:0] res;
    logic        ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0, signed_mode = 1'b0, acc_en = 1'b0, acc_clear = 1'b0;
  logic [FW-1:0] x_flat = '0, y_flat = '0;
  logic [63:0]   chain_in = '0;
  logic [63:0]   result;
  logic          out_valid, overflow;

  logic          in_valid2 = 1'b0, acc_en2 = 1'b0, acc_clear2 = 1'b0;
  logic [FW-1:0] x_flat2 = '0, y_flat2 = '0;
  logic [19:0]   chain_in2 = '0;
  logic [19:0]   result2;
  logic          out_valid2, overflow2;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_on = 1'b0;
  exp_t q[$];
  exp_t q2[$];
  logic [63:0] m_res = '0, vis_res = '0;
  logic        m_ovf = 1'b0, vis_ovf = 1'b0;

  int_sop_chain_acc #(.DATA_W(9), .LANES(4), .STAGES(2), .ACC_W(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .signed_mode(signed_mode),
    .acc_en(acc_en), .acc_clear(acc_clear), .x_flat(x_flat), .y_flat(y_flat),
    .chain_in(chain_in), .result(result), .out_valid(out_valid), .overflow(overflow)
  );

  int_sop_chain_acc #(.DATA_W(9), .LANES(4), .STAGES(2), .ACC_W(20)) dut20 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .signed_mode(1'b1),
    .acc_en(acc_en2), .acc_clear(acc_clear2), .x_flat(x_flat2), .y_flat(y_flat2),
    .chain_in(chain_in2), .result(result2), .out_valid(out_valid2), .overflow(overflow2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] fill(input logic [DW-1:0] v);
    logic [FW-1:0] r;
    for (int i = 0; i < NP; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [63:0] model_total(input logic sm, input logic [FW-1:0] xf,
                                              input logic [FW-1:0] yf, input logic [63:0] cin);
    logic [63:0]        t;
    logic signed [63:0] sa, sb;
    logic [DW-1:0]      xs, ys;
    t = cin;
    for (int i = 0; i < NP; i++) begin
      xs = xf[i*DW +: DW];
      ys = yf[i*DW +: DW];
      if (sm) begin
        sa = $signed(xs);
        sb = $signed(ys);
        t  = t + sa * sb;
      end else begin
        t = t + {55'd0, xs} * {55'd0, ys};
      end
    end
    return t;
  endfunction

  task automatic model_update(input logic sm, ae, ac, input logic [63:0] tot);
    logic [64:0] s;
    logic        o;
    if (!ae || ac) begin
      m_res = tot;
      if (ac) m_ovf = 1'b0;
    end else begin
      s = {1'b0, m_res} + {1'b0, tot};
      o = sm ? ((m_res[63] == tot[63]) && (s[63] != m_res[63])) : s[64];
      m_res = s[63:0];
      m_ovf = m_ovf | o;
    end
  endtask

  task automatic beat(input logic v, sm, ae, ac, input logic [FW-1:0] xf, yf,
                      input logic [63:0] cin);
    int   due;
    exp_t e;
    in_valid = v; signed_mode = sm; acc_en = ae; acc_clear = ac;
    x_flat = xf; y_flat = yf; chain_in = cin;
    due = cyc + 1 + LAT;
    @(posedge clk); #1;
    if (v) begin
      model_update(sm, ae, ac, model_total(sm, xf, yf, cin));
      e.due = due; e.res = m_res; e.ovf = m_ovf;
      q.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  task automatic beat2(input logic ae, ac, input logic [DW-1:0] xv, yv,
                       input logic [19:0] er, input logic eo);
    exp_t e;
    in_valid2 = 1'b1; acc_en2 = ae; acc_clear2 = ac;
    x_flat2 = fill(xv); y_flat2 = fill(yv);
    e.due = cyc + 1 + LAT; e.res = {44'd0, er}; e.ovf = eo;
    @(posedge clk); #1;
    q2.push_back(e);
    in_valid2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q.size() > 0 || q2.size() > 0); i++) begin
      @(posedge clk); #1;
    end
    check_val("drain", 64'(q.size() + q2.size()), 64'd0);
  endtask

  // Reset pulse with in_valid high to show the reset-cycle beat is dropped.
  task automatic reset_pulse();
    reset = 1'b1; in_valid = 1'b1;
    x_flat = fill(9'd3); y_flat = fill(9'd3);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    q.delete(); q2.delete();
    m_res = '0; m_ovf = 1'b0; vis_res = '0; vis_ovf = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        check_val("out_valid", {63'd0, out_valid}, 64'd1);
        check_val("result", result, e.res);
        check_val("overflow", {63'd0, overflow}, {63'd0, e.ovf});
        vis_res = e.res;
        vis_ovf = e.ovf;
      end else begin
        check_val("idle_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("hold_result", result, vis_res);
        check_val("hold_overflow", {63'd0, overflow}, {63'd0, vis_ovf});
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      if (q2.size() > 0 && q2[0].due == cyc) begin
        exp_t e;
        e = q2.pop_front();
        check_val("out_valid20", {63'd0, out_valid2}, 64'd1);
        check_val("result20", {44'd0, result2}, e.res);
        check_val("overflow20", {63'd0, overflow2}, {63'd0, e.ovf});
      end else begin
        check_val("idle_out_valid20", {63'd0, out_valid2}, 64'd0);
      end
    end
  end

  initial begin
    logic [95:0] rx, ry;
    logic        v, sm, ae, ac;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_on = 1'b1;
    idle(2);

    // Unsigned, all ones, no accumulation: 8
    beat(1'b1, 1'b0, 1'b0, 1'b0, fill(9'd1), fill(9'd1), 64'd0);
    drain();

    // Signed -256 * -256 over 8 lanes plus seed 5: 524293
    beat(1'b1, 1'b1, 1'b0, 1'b0, fill(9'h100), fill(9'h100), 64'd5);
    drain();

    // Unsigned accumulate back-to-back: 32, 64, 96
    beat(1'b1, 1'b0, 1'b1, 1'b1, fill(9'd2), fill(9'd2), 64'd0);
    beat(1'b1, 1'b0, 1'b1, 1'b0, fill(9'd2), fill(9'd2), 64'd0);
    beat(1'b1, 1'b0, 1'b1, 1'b0, fill(9'd2), fill(9'd2), 64'd0);
    drain();

    // Bubble in the middle: result must hold on the empty cycle
    beat(1'b1, 1'b0, 1'b0, 1'b0, fill(9'd7), fill(9'd5), 64'd1);
    beat(1'b0, 1'b0, 1'b0, 1'b0, fill(9'd9), fill(9'd9), 64'd0);
    beat(1'b1, 1'b1, 1'b0, 1'b0, fill(9'h1ff), fill(9'd3), 64'd0);
    drain();

    // Unsigned carry-out sets overflow; plain load keeps it; clear with acc_en=0 drops it
    beat(1'b1, 1'b0, 1'b1, 1'b1, fill(9'd0), fill(9'd0), 64'hFFFF_FFFF_FFFF_FFF0);
    beat(1'b1, 1'b0, 1'b1, 1'b0, fill(9'd1), fill(9'd1), 64'd8);
    beat(1'b1, 1'b0, 1'b0, 1'b0, fill(9'd1), fill(9'd1), 64'd0);
    beat(1'b1, 1'b0, 1'b0, 1'b1, fill(9'd1), fill(9'd1), 64'd0);
    drain();

    // Random mixed-mode traffic with bubbles
    for (int i = 0; i < 24; i++) begin
      rx = {$urandom, $urandom, $urandom};
      ry = {$urandom, $urandom, $urandom};
      v  = ($urandom_range(0, 3) != 0);
      sm = 1'($urandom_range(0, 1));
      ae = 1'($urandom_range(0, 1));
      ac = ($urandom_range(0, 4) == 0);
      beat(v, sm, ae, ac, rx[FW-1:0], ry[FW-1:0], {$urandom, $urandom});
    end
    drain();

    // Beats in flight when reset hits are discarded
    beat(1'b1, 1'b0, 1'b0, 1'b0, fill(9'd4), fill(9'd4), 64'd1);
    beat(1'b1, 1'b0, 1'b0, 1'b0, fill(9'd4), fill(9'd4), 64'd2);
    reset_pulse();
    idle(8);

    // Narrow accumulator: signed overflow into bit 19, then a clear beat
    beat2(1'b1, 1'b1, 9'h100, 9'h180, 20'd262144, 1'b0);
    beat2(1'b1, 1'b0, 9'h100, 9'h180, 20'h80000, 1'b1);
    beat2(1'b1, 1'b1, 9'h000, 9'h180, 20'd0, 1'b0);
    drain();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
